// File: rtl/rr_mux_arbiter_4.sv
// Round-robin 4:1 arbiter feeding a one-entry output register with valid/ready handshake.
// Define RR_MUX_FIXED_PRIO_EN to replace round-robin with fixed priority (d0 highest).
module rr_mux_arbiter_4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   grant_id
);

  logic               r_out_valid;
  logic [W-1:0]       r_out_data;
  logic [1:0]         r_grant_id;
  logic               w_cap;
  logic               w_xfer;
  logic [1:0]         w_win;
  logic [3:0]         w_req_ready;
  logic [3:0][W-1:0]  w_d;
`ifndef RR_MUX_FIXED_PRIO_EN
  logic [1:0]         r_ptr;
  logic [1:0]         w_idx;
`endif

  assign w_d   = {d3, d2, d1, d0};
  assign w_cap = !r_out_valid || out_ready;

  // Loops walk from lowest to highest priority so the last hit wins.
  always_comb begin
    w_xfer = 1'b0;
    w_win  = 2'd0;
`ifndef RR_MUX_FIXED_PRIO_EN
    w_idx  = 2'd0;
`endif
    if (w_cap) begin
`ifdef RR_MUX_FIXED_PRIO_EN
      for (int i = 3; i >= 0; i--) begin
        if (req_valid[i]) begin
          w_xfer = 1'b1;
          w_win  = 2'(i);
        end
      end
`else
      for (int k = 4; k >= 1; k--) begin
        w_idx = r_ptr + 2'(k);
        if (req_valid[w_idx]) begin
          w_xfer = 1'b1;
          w_win  = w_idx;
        end
      end
`endif
    end
    w_req_ready = w_xfer ? (4'b0001 << w_win) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_grant_id  <= 2'd0;
`ifndef RR_MUX_FIXED_PRIO_EN
      r_ptr       <= 2'd3;
`endif
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_d[w_win];
      r_grant_id  <= w_win;
`ifndef RR_MUX_FIXED_PRIO_EN
      r_ptr       <= w_win;
`endif
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign req_ready = w_req_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Scoreboard bench for rr_mux_arbiter_4: directed scenarios followed by random traffic.
module tb_rr_mux_arbiter_4;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   id;
  } word_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   grant_id;

  rr_mux_arbiter_4 #(.W(W)) dut (
    .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .req_valid(req_valid), .req_ready(req_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  word_t      sb[$];
  int         pend = 0;
  logic [3:0] exp_rr = 4'b0;
  bit         armed = 1'b0;
  int         checks = 0;
  int         failures = 0;

  // reference model state
  int model_ptr = 3;
  bit model_valid = 1'b0;
  bit prev_rst_low = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rv, input logic ordy,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] e);
    logic [W-1:0] dv[4];
    int win;
    bit cap;
    word_t w;
    @(posedge clk);
    #2;
    rst = r; req_valid = rv; out_ready = ordy;
    d0 = a; d1 = b; d2 = c; d3 = e;
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = e;
    #1;
    if (prev_rst_low) armed = 1'b1;
    cap = !model_valid || ordy;
    win = -1;
    if (cap) begin
`ifdef RR_MUX_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++)
        if (win < 0 && rv[i]) win = i;
`else
      for (int k = 1; k <= 4; k++)
        if (win < 0 && rv[(model_ptr + k) % 4]) win = (model_ptr + k) % 4;
`endif
    end
    exp_rr = (win >= 0) ? (4'b0001 << win) : 4'b0000;
    pend = 0;
    if (!r) begin
      model_valid = 1'b0;
      model_ptr = 3;
    end else if (win >= 0) begin
      w.d = dv[win];
      w.id = 2'(win);
      sb.push_back(w);
      pend = 1;
      model_valid = 1'b1;
      model_ptr = win;
    end else if (model_valid && ordy) begin
      model_valid = 1'b0;
    end
    prev_rst_low = !r;
  endtask

  // Monitor: compares the held word against the scoreboard front and pops on drain.
  initial begin
    logic [W-1:0] last_d;
    logic [1:0]   last_id;
    int exp_ov;
    last_d = '0;
    last_id = 2'd0;
    forever begin
      @(posedge clk);
      #4;
      if (armed) check("req_ready", int'(req_ready), int'(exp_rr));
      if (rst === 1'b1) begin
        exp_ov = sb.size() - pend;
        check("out_valid", int'(out_valid), exp_ov);
        if (exp_ov > 0) begin
          check("out_data", int'(out_data), int'(sb[0].d));
          check("grant_id", int'(grant_id), int'(sb[0].id));
          if (out_ready) begin
            last_d = sb[0].d;
            last_id = sb[0].id;
            void'(sb.pop_front());
          end
        end else begin
          check("out_data_hold", int'(out_data), int'(last_d));
          check("grant_id_hold", int'(grant_id), int'(last_id));
        end
      end else begin
        sb.delete();
        last_d = '0;
        last_id = 2'd0;
      end
    end
  end

  initial begin
    rst = 1'b0; req_valid = 4'b0; out_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    // reset while everybody requests
    step(0, 4'b1111, 1, 4'd9, 4'd9, 4'd9, 4'd9);
    step(0, 4'b1111, 1, 4'd9, 4'd9, 4'd9, 4'd9);
    // rotation: expect grants 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) step(1, 4'b1111, 1, 4'd1, 4'd2, 4'd3, 4'd4);
    // backpressure with held word from requester 1
    step(1, 4'b0010, 1, 4'd5, 4'd6, 4'd7, 4'd8);
    for (int i = 0; i < 3; i++) step(1, 4'b1111, 0, 4'd5, 4'd6, 4'd7, 4'd8);
    step(1, 4'b1111, 1, 4'd5, 4'd6, 4'd7, 4'd8);
    // skip and wrap around from ptr 2
    step(1, 4'b0100, 1, 4'd1, 4'd2, 4'd3, 4'd4);
    step(1, 4'b0010, 1, 4'd1, 4'd2, 4'd3, 4'd4);
    step(1, 4'b1001, 1, 4'd1, 4'd2, 4'd3, 4'd4);
    step(1, 4'b1001, 1, 4'd1, 4'd2, 4'd3, 4'd4);
    // drain without refill, then idle (ptr must not move)
    step(1, 4'b0000, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    step(1, 4'b0000, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    step(1, 4'b0000, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    // reset while holding a word
    step(1, 4'b0100, 0, 4'd3, 4'd3, 4'hc, 4'd3);
    step(0, 4'b1111, 0, 4'd3, 4'd3, 4'hc, 4'd3);
    step(1, 4'b0000, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 39) != 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
           W'($urandom), W'($urandom));
    for (int i = 0; i < 3; i++) step(1, 4'b0000, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    @(posedge clk);
    #6;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
